// File: rtl/grid_cursor_fsm_if.sv
// Command/status bundle between the board cursor controller and its user.
interface grid_cursor_fsm_if #(
  parameter int ROWS = 3,
  parameter int COLS = 3
);
  localparam int N  = ROWS * COLS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [PW-1:0] cmd_pos;
  logic          skip_en;
  logic [N-1:0]  occupied;
  logic          cmd_ready;
  logic          busy;
  logic [PW-1:0] pos;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          wrapped;
  logic          none_free;

  modport master (
    output cmd_valid, cmd, cmd_pos, skip_en, occupied,
    input  cmd_ready, busy, pos, row, col, wrapped, none_free
  );

  modport slave (
    input  cmd_valid, cmd, cmd_pos, skip_en, occupied,
    output cmd_ready, busy, pos, row, col, wrapped, none_free
  );
endinterface

// File: rtl/grid_cursor_fsm.sv
// Board cursor controller: linear/2-D moves, direct load and a free-cell hunt.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | accepting commands; plain moves and loads commit in 1 cycle
//  SEARCH | skip hunt in progress, one candidate cell checked per cycle
module grid_cursor_fsm #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int WRAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  grid_cursor_fsm_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [2:0] CMD_NEXT  = 3'd0;
  localparam logic [2:0] CMD_PREV  = 3'd1;
  localparam logic [2:0] CMD_UP    = 3'd2;
  localparam logic [2:0] CMD_DOWN  = 3'd3;
  localparam logic [2:0] CMD_LEFT  = 3'd4;
  localparam logic [2:0] CMD_RIGHT = 3'd5;
  localparam logic [2:0] CMD_LOAD  = 3'd6;

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] cand_q, cand_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          cand_ok_q, cand_ok_d;
  logic          pwrap_q, pwrap_d;
  logic          fwd_q, fwd_d;
  logic          busy_q, busy_d;
  logic          wrapped_q, wrapped_d;
  logic          none_free_q, none_free_d;
  logic [N-1:0]  occ_sh;

  // True when p is the last cell in the direction of travel.
  function automatic logic at_edge(input logic [PW-1:0] p, input logic fwd);
    return fwd ? (p == PW'(N - 1)) : (p == '0);
  endfunction

  // One linear step, always wrapping; callers decide whether wrapping is allowed.
  function automatic logic [PW-1:0] lin_step(input logic [PW-1:0] p, input logic fwd);
    if (at_edge(p, fwd)) return fwd ? '0 : PW'(N - 1);
    return fwd ? (p + PW'(1)) : (p - PW'(1));
  endfunction

  function automatic logic [PW-1:0] rc2pos(input int r, input int c);
    return PW'(r * COLS + c);
  endfunction

  // Occupancy of the current candidate, read live from the mask.
  assign occ_sh = bus.occupied >> cand_q;

  // Next-state and move arithmetic.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    cand_ok_d   = cand_ok_q;
    pwrap_d     = pwrap_q;
    fwd_d       = fwd_q;
    wrapped_d   = 1'b0;
    none_free_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd)
            CMD_NEXT, CMD_PREV: begin
              fwd_d = (bus.cmd == CMD_NEXT);
              if (bus.skip_en) begin
                // With no legal first candidate the hunt still costs one cycle
                // and ends in none_free, keeping busy timing uniform.
                state_d   = SEARCH;
                cand_d    = lin_step(pos_q, fwd_d);
                cnt_d     = (PW+1)'(1);
                pwrap_d   = at_edge(pos_q, fwd_d);
                cand_ok_d = (N > 1) && ((WRAP != 0) || !at_edge(pos_q, fwd_d));
              end else if (!at_edge(pos_q, fwd_d) || (WRAP != 0)) begin
                pos_d     = lin_step(pos_q, fwd_d);
                wrapped_d = at_edge(pos_q, fwd_d);
              end
            end
            CMD_UP: begin
              if (row_q != '0) pos_d = rc2pos(int'(row_q) - 1, int'(col_q));
              else if (WRAP != 0) begin
                pos_d     = rc2pos(ROWS - 1, int'(col_q));
                wrapped_d = 1'b1;
              end
            end
            CMD_DOWN: begin
              if (row_q != RW'(ROWS - 1)) pos_d = rc2pos(int'(row_q) + 1, int'(col_q));
              else if (WRAP != 0) begin
                pos_d     = rc2pos(0, int'(col_q));
                wrapped_d = 1'b1;
              end
            end
            CMD_LEFT: begin
              if (col_q != '0) pos_d = rc2pos(int'(row_q), int'(col_q) - 1);
              else if (WRAP != 0) begin
                pos_d     = rc2pos(int'(row_q), COLS - 1);
                wrapped_d = 1'b1;
              end
            end
            CMD_RIGHT: begin
              if (col_q != CW'(COLS - 1)) pos_d = rc2pos(int'(row_q), int'(col_q) + 1);
              else if (WRAP != 0) begin
                pos_d     = rc2pos(int'(row_q), 0);
                wrapped_d = 1'b1;
              end
            end
            CMD_LOAD: begin
              if (int'(bus.cmd_pos) < N) pos_d = bus.cmd_pos;
            end
            default: ;
          endcase
        end
      end
      SEARCH: begin
        if (cand_ok_q && !occ_sh[0]) begin
          pos_d     = cand_q;
          wrapped_d = pwrap_q;
          state_d   = IDLE;
        end else if (!cand_ok_q || (cnt_q == (PW+1)'(N - 1)) ||
                     ((WRAP == 0) && at_edge(cand_q, fwd_q))) begin
          none_free_d = 1'b1;
          state_d     = IDLE;
        end else begin
          pwrap_d = pwrap_q | at_edge(cand_q, fwd_q);
          cand_d  = lin_step(cand_q, fwd_q);
          cnt_d   = cnt_q + (PW+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEARCH);
    row_d  = RW'(int'(pos_d) / COLS);
    col_d  = CW'(int'(pos_d) % COLS);
  end

  // State and registered outputs; reset abandons any hunt without pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      cand_ok_q   <= 1'b0;
      pwrap_q     <= 1'b0;
      fwd_q       <= 1'b0;
      busy_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      none_free_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      cand_ok_q   <= cand_ok_d;
      pwrap_q     <= pwrap_d;
      fwd_q       <= fwd_d;
      busy_q      <= busy_d;
      wrapped_q   <= wrapped_d;
      none_free_q <= none_free_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_ready = ~busy_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.none_free = none_free_q;
endmodule

// File: tb/tb_grid_cursor_fsm.sv
// Bench for the cursor controller: a wrapping and a saturating 3x3 instance
// driven by the same stimulus.
module tb_grid_cursor_fsm;
  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int N    = 9;
  localparam logic [2:0] C_NEXT = 3'd0, C_PREV = 3'd1, C_UP = 3'd2, C_DOWN = 3'd3;
  localparam logic [2:0] C_LEFT = 3'd4, C_RIGHT = 3'd5, C_LOAD = 3'd6, C_NOP = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cmd_valid;
  logic [2:0] cmd;
  logic [3:0] cmd_pos;
  logic       skip_en;
  logic [8:0] occupied;

  grid_cursor_fsm_if #(.ROWS(ROWS), .COLS(COLS)) ifw ();
  grid_cursor_fsm_if #(.ROWS(ROWS), .COLS(COLS)) ifs ();

  assign ifw.cmd_valid = cmd_valid;
  assign ifw.cmd       = cmd;
  assign ifw.cmd_pos   = cmd_pos;
  assign ifw.skip_en   = skip_en;
  assign ifw.occupied  = occupied;
  assign ifs.cmd_valid = cmd_valid;
  assign ifs.cmd       = cmd;
  assign ifs.cmd_pos   = cmd_pos;
  assign ifs.skip_en   = skip_en;
  assign ifs.occupied  = occupied;

  grid_cursor_fsm #(.ROWS(ROWS), .COLS(COLS), .WRAP(1)) dut_w (.clk(clk), .rst(rst), .bus(ifw));
  grid_cursor_fsm #(.ROWS(ROWS), .COLS(COLS), .WRAP(0)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Position (with derived row/col) and wrap pulse of both instances.
  task automatic chk_pos(input string nm, input int pw, input int ww, input int ps, input int ws);
    chk({nm, " w.pos"}, int'(ifw.pos), pw);
    chk({nm, " w.row"}, int'(ifw.row), pw / COLS);
    chk({nm, " w.col"}, int'(ifw.col), pw % COLS);
    chk({nm, " w.wrapped"}, int'(ifw.wrapped), ww);
    chk({nm, " s.pos"}, int'(ifs.pos), ps);
    chk({nm, " s.row"}, int'(ifs.row), ps / COLS);
    chk({nm, " s.col"}, int'(ifs.col), ps % COLS);
    chk({nm, " s.wrapped"}, int'(ifs.wrapped), ws);
  endtask

  task automatic set_idle();
    cmd_valid = 1'b0; cmd = C_NOP; cmd_pos = '0; skip_en = 1'b0;
  endtask

  // Presents one command for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] c, input int p, input logic sk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_pos = 4'(p); skip_en = sk;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Skip hunt: checks busy length, pulse counts and final cursor of both instances.
  task automatic search(input string nm, input int start, input logic [2:0] c,
                        input logic [8:0] occ, input bit inject,
                        input int kw_e, input int ks_e, input int pw_e, input int ps_e,
                        input int nfw_e, input int nfs_e, input int wrw_e);
    int kw, ks, nfw, nfs, wrw, wrs, n;
    kw = 0; ks = 0; nfw = 0; nfs = 0; wrw = 0; wrs = 0; n = 0;
    issue(C_LOAD, start, 1'b0);
    occupied = occ;
    issue(c, 0, 1'b1);
    if (inject) begin cmd_valid = 1'b1; cmd = C_LOAD; cmd_pos = 4'd7; skip_en = 1'b0; end
    while ((ifw.busy || ifs.busy) && n < 40) begin
      if (ifw.busy) kw++;
      if (ifs.busy) ks++;
      chk({nm, " ready"}, int'(ifw.cmd_ready), int'(!ifw.busy));
      @(negedge clk); n++;
      if (ifw.none_free) nfw++;
      if (ifs.none_free) nfs++;
      if (ifw.wrapped) wrw++;
      if (ifs.wrapped) wrs++;
    end
    cmd_valid = 1'b0;
    chk({nm, " in_time"}, int'(n < 40), 1);
    repeat (2) begin
      @(negedge clk);
      if (ifw.none_free) nfw++;
      if (ifs.none_free) nfs++;
      if (ifw.wrapped) wrw++;
      if (ifs.wrapped) wrs++;
    end
    chk({nm, " w.busy_cycles"}, kw, kw_e);
    chk({nm, " s.busy_cycles"}, ks, ks_e);
    chk({nm, " w.none_free"}, nfw, nfw_e);
    chk({nm, " s.none_free"}, nfs, nfs_e);
    chk({nm, " w.wrapped_cnt"}, wrw, wrw_e);
    chk({nm, " s.wrapped_cnt"}, wrs, 0);
    chk_pos(nm, pw_e, 0, ps_e, 0);
  endtask

  // Reference model: a skip hunt is the precomputed list of cells it may visit.
  int m_pos[2], m_busy[2], m_wr[2], m_nf[2], m_len[2], m_idx[2];
  int m_cand[2][16];
  int m_cw[2][16];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pos[m] = 0; m_busy[m] = 0; m_wr[m] = 0; m_nf[m] = 0; m_len[m] = 0; m_idx[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input int wrap);
    int p, r, c, q;
    m_wr[m] = 0; m_nf[m] = 0;
    p = m_pos[m]; r = p / COLS; c = p % COLS;
    if (m_busy[m] != 0) begin
      if (m_idx[m] >= m_len[m]) begin
        m_nf[m] = 1; m_busy[m] = 0;
      end else if (!occupied[m_cand[m][m_idx[m]]]) begin
        m_pos[m] = m_cand[m][m_idx[m]]; m_wr[m] = m_cw[m][m_idx[m]]; m_busy[m] = 0;
      end else begin
        m_idx[m]++;
        if (m_idx[m] == m_len[m]) begin m_nf[m] = 1; m_busy[m] = 0; end
      end
    end else if (cmd_valid) begin
      case (cmd)
        C_NEXT, C_PREV: begin
          if (skip_en) begin
            m_busy[m] = 1; m_len[m] = 0; m_idx[m] = 0;
            for (int j = 1; j < N; j++) begin
              q = (cmd == C_NEXT) ? p + j : p - j;
              if (q >= N || q < 0) begin
                if (wrap == 0) break;
                m_cand[m][m_len[m]] = (q + N) % N; m_cw[m][m_len[m]] = 1;
              end else begin
                m_cand[m][m_len[m]] = q; m_cw[m][m_len[m]] = 0;
              end
              m_len[m]++;
            end
          end else begin
            q = (cmd == C_NEXT) ? p + 1 : p - 1;
            if (q >= N || q < 0) begin
              if (wrap != 0) begin m_pos[m] = (q + N) % N; m_wr[m] = 1; end
            end else m_pos[m] = q;
          end
        end
        C_UP, C_DOWN: begin
          q = (cmd == C_DOWN) ? r + 1 : r - 1;
          if (q >= ROWS || q < 0) begin
            if (wrap != 0) begin m_pos[m] = ((q + ROWS) % ROWS) * COLS + c; m_wr[m] = 1; end
          end else m_pos[m] = q * COLS + c;
        end
        C_LEFT, C_RIGHT: begin
          q = (cmd == C_RIGHT) ? c + 1 : c - 1;
          if (q >= COLS || q < 0) begin
            if (wrap != 0) begin m_pos[m] = r * COLS + (q + COLS) % COLS; m_wr[m] = 1; end
          end else m_pos[m] = r * COLS + q;
        end
        C_LOAD: if (int'(cmd_pos) < N) m_pos[m] = int'(cmd_pos);
        default: ;
      endcase
    end
  endtask

  task automatic cmp_model(input int t);
    string s;
    s = $sformatf("rnd%0d", t);
    chk_pos(s, m_pos[0], m_wr[0], m_pos[1], m_wr[1]);
    chk({s, " w.busy"}, int'(ifw.busy), m_busy[0]);
    chk({s, " s.busy"}, int'(ifs.busy), m_busy[1]);
    chk({s, " w.ready"}, int'(ifw.cmd_ready), 1 - m_busy[0]);
    chk({s, " s.ready"}, int'(ifs.cmd_ready), 1 - m_busy[1]);
    chk({s, " w.none_free"}, int'(ifw.none_free), m_nf[0]);
    chk({s, " s.none_free"}, int'(ifs.none_free), m_nf[1]);
  endtask

  typedef struct {
    int cmd;
    int cmd_pos;
    int start;
    int exp_w;
    int exp_w_wr;
    int exp_s;
  } vec_t;

  vec_t vec[13];

  initial begin
    int nf;
    vec[0]  = '{int'(C_NEXT),  0, 8, 0, 1, 8};
    vec[1]  = '{int'(C_PREV),  0, 0, 8, 1, 0};
    vec[2]  = '{int'(C_UP),    0, 1, 7, 1, 1};
    vec[3]  = '{int'(C_DOWN),  0, 7, 1, 1, 7};
    vec[4]  = '{int'(C_LEFT),  0, 3, 5, 1, 3};
    vec[5]  = '{int'(C_RIGHT), 0, 5, 3, 1, 5};
    vec[6]  = '{int'(C_RIGHT), 0, 4, 5, 0, 5};
    vec[7]  = '{int'(C_DOWN),  0, 4, 7, 0, 7};
    vec[8]  = '{int'(C_LOAD),  5, 0, 5, 0, 5};
    vec[9]  = '{int'(C_LOAD),  9, 2, 2, 0, 2};
    vec[10] = '{int'(C_NOP),   3, 6, 6, 0, 6};
    vec[11] = '{int'(C_NEXT),  0, 3, 4, 0, 4};
    vec[12] = '{int'(C_UP),    0, 4, 1, 0, 1};

    set_idle();
    occupied = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk_pos("reset", 0, 0, 0, 0);
    chk("reset w.busy", int'(ifw.busy), 0);
    chk("reset s.busy", int'(ifs.busy), 0);
    chk("reset w.ready", int'(ifw.cmd_ready), 1);
    chk("reset w.none_free", int'(ifw.none_free), 0);

    // Nine back-to-back NEXT commands from reset
    cmd_valid = 1'b1; cmd = C_NEXT; skip_en = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk_pos($sformatf("next%0d", i), i % 9, int'(i == 9), (i > 8) ? 8 : i, 0);
    end
    cmd_valid = 1'b0;

    // Single-cycle command table
    for (int i = 0; i < 13; i++) begin
      issue(C_LOAD, vec[i].start, 1'b0);
      issue(3'(vec[i].cmd), vec[i].cmd_pos, 1'b0);
      chk_pos($sformatf("vec%0d", i), vec[i].exp_w, vec[i].exp_w_wr, vec[i].exp_s, 0);
    end

    // Skip hunts: short hunt with a dropped LOAD, full board, wrapping path, PREV from 0
    search("skip_short", 0, C_NEXT, 9'b000001110, 1'b1, 4, 4, 4, 4, 0, 0, 0);
    search("skip_full", 2, C_NEXT, 9'h1FF, 1'b0, 8, 6, 2, 2, 1, 1, 0);
    search("skip_wrap", 7, C_NEXT, 9'b110000001, 1'b0, 3, 1, 1, 7, 0, 1, 1);
    search("skip_prev0", 0, C_PREV, 9'b000000000, 1'b0, 1, 1, 8, 0, 0, 1, 1);

    // Reset in the middle of a hunt
    issue(C_LOAD, 2, 1'b0);
    occupied = 9'h1FF;
    issue(C_NEXT, 0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_pos("rst_mid", 0, 0, 0, 0);
    chk("rst_mid w.busy", int'(ifw.busy), 0);
    chk("rst_mid s.busy", int'(ifs.busy), 0);
    chk("rst_mid w.none_free", int'(ifw.none_free), 0);
    @(negedge clk);
    rst = 1'b0;
    nf = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifw.none_free || ifs.none_free || ifw.busy || ifs.busy) nf++;
    end
    chk("rst_mid quiet", nf, 0);
    occupied = '0;
    issue(C_NEXT, 0, 1'b0);
    chk_pos("rst_mid after", 1, 0, 1, 0);

    // Randomised commands against the reference model
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      cmp_model(t);
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd       = 3'($urandom_range(0, 7));
      cmd_pos   = 4'($urandom_range(0, 15));
      skip_en   = ($urandom_range(0, 2) == 0);
      occupied  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom & $urandom);
      model_step(0, 1);
      model_step(1, 0);
    end
    @(negedge clk);
    cmp_model(600);
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
